// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;
  typedef enum logic {
    CPU_PRI  = 1'b0,
    DBG_LOCK = 1'b1
  } arb_state_t;

  localparam int MAX_WAIT_DEF = 4;
  localparam int STALL_W      = 16;
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at MAX; clear wins over increment.
module sat_counter #(
  parameter int           W   = 4,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (inc && cnt != MAX) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU priority, bounded debug starvation,
// and a debug lock mode for bursts.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              dbg_valid_i,
  output logic              dbg_ready_o,
  input  logic              dbg_we_i,
  input  logic              dbg_lock_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [15:0]       stall_cnt_o
);
  localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  arb_state_t        state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              dbg_hs, cpu_gnt, locked;

  assign locked      = (state == DBG_LOCK);
  assign dbg_ready_o = locked || !cpu_req_i || (wait_cnt == WAIT_MAX);
  assign dbg_hs      = dbg_valid_i && dbg_ready_o;
  assign cpu_gnt     = !dbg_hs && cpu_req_i && !locked;
  assign cpu_stall_o = cpu_req_i && (locked || dbg_hs);
  assign cpu_rdata_o = mem_rdata_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= CPU_PRI;
    else          state <= state_nxt;
  end

  // Every debug handshake re-decides ownership from its lock bit.
  always_comb begin
    state_nxt = state;
    if (dbg_hs) state_nxt = dbg_lock_i ? DBG_LOCK : CPU_PRI;
  end

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (dbg_hs) begin
      mem_en_o    = 1'b1;
      mem_we_o    = dbg_we_i;
      mem_addr_o  = dbg_addr_i;
      mem_wdata_o = dbg_wdata_i;
    end else if (cpu_gnt) begin
      mem_en_o    = 1'b1;
      mem_we_o    = cpu_we_i;
      mem_addr_o  = cpu_addr_i;
      mem_wdata_o = cpu_wdata_i;
    end
  end

  // Clearing whenever the request is not being denied keeps the count tied
  // to consecutive denials of one pending request.
  sat_counter #(.W(WAIT_W), .MAX(WAIT_MAX)) u_wait_cnt (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .inc   (dbg_valid_i && !dbg_ready_o),
    .clr   (dbg_hs || !dbg_valid_i),
    .cnt   (wait_cnt)
  );

  sat_counter #(.W(STALL_W), .MAX({STALL_W{1'b1}})) u_stall_cnt (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .inc   (cpu_stall_o),
    .clr   (1'b0),
    .cnt   (stall_cnt_o)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dbg_rvalid_o <= 1'b0;
      dbg_rdata_o  <= '0;
    end else begin
      dbg_rvalid_o <= dbg_hs && !dbg_we_i;
      if (dbg_hs && !dbg_we_i) dbg_rdata_o <= mem_rdata_i;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench: behavioural arbiter model plus directed and random stimulus.
module tb_dmem_arbiter;
  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dbg_valid, dbg_we, dbg_lock;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_stall, dbg_ready, dbg_rvalid, mem_en, mem_we;
  logic [15:0] stall_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(MAXW)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
    .dbg_valid_i(dbg_valid), .dbg_ready_o(dbg_ready), .dbg_we_i(dbg_we),
    .dbg_lock_i(dbg_lock), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .stall_cnt_o(stall_cnt)
  );

  function automatic int idx(input logic [31:0] a);
    return int'(a[7:2]);
  endfunction

  // Environment memory, driven only by the DUT's memory port.
  logic [31:0] mem [0:63];
  assign mem_rdata = mem[idx(mem_addr)];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
      mem[0] <= 32'd5;
      mem[1] <= 32'd6;
    end else if (mem_en && mem_we) mem[idx(mem_addr)] <= mem_wdata;
  end

  // Reference model: ownership flag, denial count, stall tally, own memory copy.
  bit          m_locked;
  int          m_wait, m_stall;
  bit          m_rvalid;
  logic [31:0] m_rdata;
  logic [31:0] ref_mem [0:63];
  bit          e_ready, e_dbg, e_cpu, e_stall;

  always_comb begin
    e_ready = m_locked || !cpu_req || (m_wait >= MAXW);
    e_dbg   = dbg_valid && e_ready;
    e_cpu   = !e_dbg && cpu_req && !m_locked;
    e_stall = cpu_req && (m_locked || e_dbg);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_locked <= 1'b0; m_wait <= 0; m_stall <= 0;
      m_rvalid <= 1'b0; m_rdata <= 32'd0;
      for (int i = 0; i < 64; i++) ref_mem[i] <= 32'd0;
      ref_mem[0] <= 32'd5;
      ref_mem[1] <= 32'd6;
    end else begin
      if (e_dbg) m_locked <= dbg_lock;
      m_wait   <= (dbg_valid && !e_ready) ? ((m_wait < MAXW) ? m_wait + 1 : MAXW) : 0;
      if (e_stall && m_stall < 65535) m_stall <= m_stall + 1;
      m_rvalid <= e_dbg && !dbg_we;
      if (e_dbg && !dbg_we) m_rdata <= ref_mem[idx(dbg_addr)];
      if (e_dbg && dbg_we) ref_mem[idx(dbg_addr)] <= dbg_wdata;
      else if (e_cpu && cpu_we) ref_mem[idx(cpu_addr)] <= cpu_wdata;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready", dbg_ready, e_ready);
      chk("stall", cpu_stall, e_stall);
      chk("mem_en", mem_en, e_dbg || e_cpu);
      chk("mem_we", mem_we, e_dbg ? dbg_we : (e_cpu ? cpu_we : 1'b0));
      chk("mem_addr", mem_addr, e_dbg ? dbg_addr : (e_cpu ? cpu_addr : 32'd0));
      chk("mem_wdata", mem_wdata, e_dbg ? dbg_wdata : (e_cpu ? cpu_wdata : 32'd0));
      if (e_cpu && !cpu_we) chk("cpu_rdata", cpu_rdata, ref_mem[idx(cpu_addr)]);
      chk("stall_cnt", stall_cnt, 64'(m_stall));
      chk("rvalid", dbg_rvalid, m_rvalid);
      chk("dbg_rdata", dbg_rdata, m_rdata);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic dbg_set(input bit v, input bit we, input bit lk,
                         input logic [31:0] a, input logic [31:0] d);
    dbg_valid = v; dbg_we = we; dbg_lock = lk; dbg_addr = a; dbg_wdata = d;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, waited;
    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_set(0, 0, 0, 0, 0);
    repeat (3) tick();
    mid();
    chk("rst mem_en", mem_en, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst stall", cpu_stall, 0);
    chk("rst stall_cnt", stall_cnt, 0);
    chk("rst rvalid", dbg_rvalid, 0);
    chk("rst rdata", dbg_rdata, 0);
    tick();
    rst_n = 1'b1;

    // CPU read of 0x04
    cpu_req = 1; cpu_addr = 32'h4;
    mid();
    chk("cpu rd en", mem_en, 1);
    chk("cpu rd data", cpu_rdata, 6);
    chk("cpu rd stall", cpu_stall, 0);
    tick();

    // debug write then read
    cpu_req = 0;
    dbg_set(1, 1, 0, 32'h8, 32'd77);
    mid();
    chk("dbg wr ready", dbg_ready, 1);
    tick();
    dbg_set(0, 0, 0, 0, 0);
    chk("dbg wr mem[2]", mem[2], 77);
    dbg_set(1, 0, 0, 32'h0, 0);
    tick();
    dbg_set(0, 0, 0, 0, 0);
    chk("dbg rd rvalid", dbg_rvalid, 1);
    chk("dbg rd data", dbg_rdata, 5);
    tick();
    chk("dbg rd pulse end", dbg_rvalid, 0);
    chk("dbg rd hold", dbg_rdata, 5);

    // starvation bound
    base = int'(stall_cnt);
    cpu_req = 1; cpu_addr = 32'hC;
    dbg_set(1, 0, 0, 32'h4, 0);
    for (int i = 1; i <= MAXW + 1; i++) begin
      mid();
      chk("starve ready", dbg_ready, (i == MAXW + 1));
      chk("starve stall", cpu_stall, (i == MAXW + 1));
      chk("starve addr", mem_addr, (i == MAXW + 1) ? 32'h4 : 32'hC);
      tick();
    end
    dbg_set(0, 0, 0, 0, 0);
    chk("starve rdata", dbg_rdata, 6);
    chk("starve stall_cnt", stall_cnt, 64'(base + 1));
    dbg_set(1, 0, 0, 32'h4, 0);
    mid();
    chk("starve wait cleared", dbg_ready, 0);
    tick();
    dbg_set(0, 0, 0, 0, 0);
    tick();

    // locked burst with a 2-cycle gap
    cpu_addr = 32'h20;
    dbg_set(1, 1, 1, 32'h10, 32'hA0);
    waited = 0;
    mid();
    while (!dbg_ready && waited < 10) begin
      tick(); mid(); waited++;
    end
    chk("burst grant bound", (waited < 10), 1);
    base = int'(stall_cnt);
    chk("burst b0 stall", cpu_stall, 1);
    tick();
    dbg_set(1, 1, 1, 32'h14, 32'hA1);
    mid();
    chk("burst b1 ready", dbg_ready, 1);
    chk("burst b1 stall", cpu_stall, 1);
    tick();
    dbg_set(0, 0, 0, 0, 0);
    repeat (2) begin
      mid();
      chk("burst gap stall", cpu_stall, 1);
      chk("burst gap en", mem_en, 0);
      tick();
    end
    dbg_set(1, 1, 0, 32'h18, 32'hA2);
    mid();
    chk("burst b2 stall", cpu_stall, 1);
    tick();
    dbg_set(0, 0, 0, 0, 0);
    mid();
    chk("burst cpu stall", cpu_stall, 0);
    chk("burst cpu addr", mem_addr, 32'h20);
    chk("burst stall_cnt", stall_cnt, 64'(base + 5));
    chk("burst mem4", mem[4], 32'hA0);
    chk("burst mem5", mem[5], 32'hA1);
    chk("burst mem6", mem[6], 32'hA2);
    tick();

    // reset while locked
    cpu_req = 0;
    dbg_set(1, 1, 1, 32'h24, 32'h55);
    tick();
    dbg_set(0, 0, 0, 0, 0);
    cpu_req = 1;
    mid();
    chk("lock stall", cpu_stall, 1);
    #2 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mid();
    chk("post-rst stall", cpu_stall, 0);
    chk("post-rst en", mem_en, 1);
    chk("post-rst stall_cnt", stall_cnt, 0);
    tick();

    // stall counter saturation under lock
    cpu_req = 0;
    dbg_set(1, 1, 1, 32'h28, 32'h1);
    tick();
    dbg_set(0, 0, 0, 0, 0);
    cpu_req = 1;
    repeat (65600) tick();
    chk("sat value", stall_cnt, 16'hFFFF);
    repeat (3) tick();
    chk("sat hold", stall_cnt, 16'hFFFF);
    dbg_set(1, 1, 0, 32'h28, 32'h2);
    tick();
    dbg_set(0, 0, 0, 0, 0);

    // random traffic, checked every cycle by the compare process
    #2 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 600; i++) begin
      cpu_req   = ($urandom_range(0, 3) != 0);
      cpu_we    = $urandom_range(0, 1);
      cpu_addr  = $urandom_range(0, 255);
      cpu_wdata = $urandom;
      dbg_set($urandom_range(0, 4) != 0, $urandom_range(0, 1),
              $urandom_range(0, 5) == 0, $urandom_range(0, 255), $urandom);
      tick();
    end
    cpu_req = 0;
    dbg_set(1, 0, 0, 32'h0, 0);
    tick();
    dbg_set(0, 0, 0, 0, 0);
    mid();
    chk("final unlocked", cpu_stall, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
